// File: rtl/sd_dma_sink_if.sv
// -----------------------------------------------------------------------------
// sd_dma_sink_if
//   Wishbone bus bundle between the SD controller's DMA master port and the
//   sd_dma_sink slave. Signal names keep the slave-side _i/_o suffixes used on
//   the controller's bus so both ends read the same.
//
//   wb_adr_i  [31:0]  address (not decoded by the sink)
//   wb_dat_i  [31:0]  write data
//   wb_sel_i  [3:0]   byte selects
//   wb_we_i           write enable
//   wb_cyc_i          bus cycle
//   wb_stb_i          strobe
//   wb_cti_i  [2:0]   cycle type (not decoded by the sink)
//   wb_bte_i  [1:0]   burst type (not decoded by the sink)
//   wb_ack_o          single-cycle acknowledge from the slave
//   wb_dat_o  [31:0]  read data from the slave
//
//   Modports: master drives requests, slave drives ack and read data.
// -----------------------------------------------------------------------------
interface sd_dma_sink_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
      input  wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      output wb_ack_o, wb_dat_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
      output wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      input  wb_ack_o, wb_dat_o
   );
endinterface

// File: rtl/sd_dma_sink.sv
// -----------------------------------------------------------------------------
// sd_dma_sink
//   Wishbone slave terminating the SD controller's DMA master port. Full-word
//   writes are queued in a word FIFO, unpacked into a byte stream and counted
//   into fixed-size blocks for the downstream frame decoder.
//
//   Parameters
//     FIFO_DEPTH_LOG2   FIFO holds 2^N 32-bit words (2..10)
//     BLOCK_BYTES_LOG2  block length is 2^N bytes
//
//   Compile-time option
//     SD_DMA_SINK_BYTE_SWAP_EN  defined: word[31:24] is streamed first
//                               undefined: word[7:0] is streamed first
//
//   Ports
//     clk           single clock, also the Wishbone clock
//     reset_n       asynchronous reset, active low
//     wb            Wishbone slave bundle (sd_dma_sink_if.slave)
//     flush         synchronous clear of FIFO, unpacker and block counter
//     out_data      stream byte
//     out_valid     stream valid
//     out_ready     stream ready
//     block_done    one-cycle pulse after the last byte of a block is taken
//     fifo_level    words currently held in the FIFO
//     overflow_err  sticky: a write arrived with a partial byte select
// -----------------------------------------------------------------------------
module sd_dma_sink #(
   parameter int FIFO_DEPTH_LOG2  = 6,
   parameter int BLOCK_BYTES_LOG2 = 9
) (
   input  logic                     clk,
   input  logic                     reset_n,
   sd_dma_sink_if.slave             wb,
   input  logic                     flush,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     block_done,
   output logic [FIFO_DEPTH_LOG2:0] fifo_level,
   output logic                     overflow_err
);

   localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int          LW    = FIFO_DEPTH_LOG2 + 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } bus_state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   bus_state_t                  state;
   logic                        ack_q;
   logic                        ovf_q;

   logic [31:0]                 mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr;
   logic [LW-1:0]               level;

   logic [31:0]                 word_q;
   logic [1:0]                  idx_q;
   logic                        valid_q;

   logic [BLOCK_BYTES_LOG2-1:0] byte_cnt;
   logic                        done_q;

   // ---------------------------------------------------------------------
   // Control decode
   // ---------------------------------------------------------------------
   logic req;
   logic has_space;
   logic take_req;
   logic push;
   logic pop;
   logic accept;
   logic last_byte;

   assign req       = wb.wb_cyc_i & wb.wb_stb_i;
   // Space test uses the registered level only, so a pop on the same edge
   // cannot make room for a push; a full FIFO simply inserts wait states.
   assign has_space = (level < LW'(DEPTH));
   assign take_req  = (state == S_IDLE) & req & has_space & ~flush;
   assign push      = take_req & wb.wb_we_i & (wb.wb_sel_i == 4'hF);

   assign accept    = valid_q & out_ready;
   assign last_byte = accept & (idx_q == 2'd3);
   // Reload straight from the FIFO head when the unpacker is empty or its
   // last byte leaves this cycle, so consecutive words stream with no bubble.
   assign pop       = ~flush & (level != '0) & (~valid_q | last_byte);

   // Address, cycle type and burst type carry no meaning for this sink.
   logic unused_bus;
   assign unused_bus = ^{wb.wb_adr_i, wb.wb_cti_i, wb.wb_bte_i};

   // ---------------------------------------------------------------------
   // Bus FSM: IDLE -> ACK on an accepted request, ACK -> IDLE always.
   // Returning through IDLE guarantees a request is never acked twice.
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         ack_q <= 1'b0;
         ovf_q <= 1'b0;
      end else if (flush) begin
         // overflow_err deliberately survives a flush.
         state <= S_IDLE;
         ack_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (take_req) begin
                  state <= S_ACK;
                  ack_q <= 1'b1;
                  if (wb.wb_we_i && (wb.wb_sel_i != 4'hF)) begin
                     ovf_q <= 1'b1;
                  end
               end
            end
            S_ACK: begin
               state <= S_IDLE;
               ack_q <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               ack_q <= 1'b0;
            end
         endcase
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = '0;
   assign overflow_err = ovf_q;

   // ---------------------------------------------------------------------
   // Word FIFO
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // NOTE: the storage array has no reset; the pointers and level decide
   // which entries are meaningful, so clearing the array would only cost logic.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wb.wb_dat_i;
      end
   end

   assign fifo_level = level;

   // ---------------------------------------------------------------------
   // Unpacker: one held word plus the index of the byte on the stream.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else if (pop) begin
         word_q  <= mem[rd_ptr];
         idx_q   <= '0;
         valid_q <= 1'b1;
      end else if (accept) begin
         idx_q <= idx_q + 1'b1;
         if (idx_q == 2'd3) begin
            valid_q <= 1'b0;
         end
      end
   end

   // Byte select from held registers only, so out_data cannot change while
   // the consumer stalls.
   // NOTE: combinational blocks assign a default first so no path can leave
   // the output unassigned and infer a latch.
   always_comb begin
      out_data = 8'h00;
`ifdef SD_DMA_SINK_BYTE_SWAP_EN
      case (idx_q)
         2'd0:    out_data = word_q[31:24];
         2'd1:    out_data = word_q[23:16];
         2'd2:    out_data = word_q[15:8];
         default: out_data = word_q[7:0];
      endcase
`else
      case (idx_q)
         2'd0:    out_data = word_q[7:0];
         2'd1:    out_data = word_q[15:8];
         2'd2:    out_data = word_q[23:16];
         default: out_data = word_q[31:24];
      endcase
`endif
   end

   assign out_valid = valid_q;

   // ---------------------------------------------------------------------
   // Block tracker: the accept that wraps the counter to zero ends a block.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_cnt <= '0;
         done_q   <= 1'b0;
      end else if (flush) begin
         byte_cnt <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= accept & (byte_cnt == '1);
         if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
         end
      end
   end

   assign block_done = done_q;

endmodule

// File: tb/tb_sd_dma_sink.sv
// -----------------------------------------------------------------------------
// tb_sd_dma_sink
//   Self-checking bench for sd_dma_sink. A byte queue models the stream: each
//   acknowledged full-word write appends its four bytes in wire order, and a
//   monitor compares every accepted byte, block_done pulses (from a running
//   byte count modulo the block size) and out_data stability under stall.
//   Scenario tasks run in sequence from one initial block.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_dma_sink;

   localparam int FIFO_DEPTH_LOG2  = 6;
   localparam int BLOCK_BYTES_LOG2 = 9;
   localparam int DEPTH            = 1 << FIFO_DEPTH_LOG2;
   localparam int BLOCK            = 1 << BLOCK_BYTES_LOG2;

   logic                     clk;
   logic                     reset_n;
   logic                     flush;
   logic [7:0]               out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     block_done;
   logic [FIFO_DEPTH_LOG2:0] fifo_level;
   logic                     overflow_err;

   sd_dma_sink_if bus ();

   sd_dma_sink #(
      .FIFO_DEPTH_LOG2  (FIFO_DEPTH_LOG2),
      .BLOCK_BYTES_LOG2 (BLOCK_BYTES_LOG2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wb           (bus),
      .flush        (flush),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .block_done   (block_done),
      .fifo_level   (fifo_level),
      .overflow_err (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc_cnt  = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   logic [7:0] exp_q[$];
   int         acc_cyc[$];
   int         stream_cnt  = 0;
   int         done_pulses = 0;
   bit         pend_done   = 0;
   bit         prev_stall  = 0;
   logic [7:0] prev_data   = '0;

   function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
`ifdef SD_DMA_SINK_BYTE_SWAP_EN
      return 8'((w >> (8 * (3 - k))) & 32'hFF);
`else
      return 8'((w >> (8 * k)) & 32'hFF);
`endif
   endfunction

   function automatic void model_push(input logic [31:0] w);
      for (int k = 0; k < 4; k++) exp_q.push_back(byte_of(w, k));
   endfunction

   function automatic void model_clear();
      exp_q.delete();
      stream_cnt = 0;
   endfunction

   // Stream monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (reset_n && !flush) begin
         if (pend_done || block_done) begin
            n_checks++;
            if (block_done !== pend_done) begin
               n_fails++;
               $display("FAIL block_done: got %0b want %0b (byte %0d)", block_done, pend_done, stream_cnt);
            end
         end
         if (block_done) done_pulses++;
         if (prev_stall) begin
            n_checks++;
            if (out_data !== prev_data) begin
               n_fails++;
               $display("FAIL stall_stable: got %02h want %02h", out_data, prev_data);
            end
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fails++;
               $display("FAIL stream_byte: got %02h want no byte", out_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  n_fails++;
                  $display("FAIL stream_byte: got %02h want %02h", out_data, e);
               end
            end
            acc_cyc.push_back(cyc_cnt);
            pend_done = ((stream_cnt % BLOCK) == BLOCK - 1);
            stream_cnt++;
         end else begin
            pend_done = 0;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end else begin
         pend_done  = 0;
         prev_stall = 0;
      end
   end

   // ---------------------------------------------------------------------
   // Bus master helpers
   // ---------------------------------------------------------------------
   task automatic wb_drive(input logic [31:0] d, input logic [3:0] sel, input logic we);
      @(posedge clk); #1;
      bus.wb_adr_i = $urandom;
      bus.wb_dat_i = d;
      bus.wb_sel_i = sel;
      bus.wb_we_i  = we;
      bus.wb_cti_i = 3'($urandom_range(0, 7));
      bus.wb_bte_i = 2'($urandom_range(0, 3));
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
   endtask

   // Waits up to limit cycles for ack. On ack, ends the cycle and checks
   // the ack lasted exactly one cycle; otherwise leaves the request up.
   task automatic wb_wait(input int limit, output bit acked, output logic [31:0] rd);
      acked = 0;
      rd    = 'x;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.wb_ack_o === 1'b1) begin
            acked = 1;
            rd    = bus.wb_dat_o;
            break;
         end
      end
      if (acked) begin
         @(posedge clk); #1;
         bus.wb_cyc_i = 1'b0;
         bus.wb_stb_i = 1'b0;
         @(negedge clk);
         n_checks++;
         if (bus.wb_ack_o !== 1'b0) begin
            n_fails++;
            $display("FAIL ack_width: got %0b want 0 one cycle after ack", bus.wb_ack_o);
         end
      end
   endtask

   task automatic wb_write(input logic [31:0] d, input logic [3:0] sel);
      bit          acked;
      logic [31:0] rd;
      wb_drive(d, sel, 1'b1);
      wb_wait(2000, acked, rd);
      n_checks++;
      if (!acked) begin
         n_fails++;
         $display("FAIL write_ack_timeout: got no ack want ack for %08h", d);
         bus.wb_cyc_i = 1'b0;
         bus.wb_stb_i = 1'b0;
      end else if (sel == 4'hF) begin
         model_push(d);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL %s_drain: got %0d bytes missing want 0", name, exp_q.size());
      end
   endtask

   task automatic do_flush();
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      model_clear();
   endtask

   // ---------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks += 7;
      if (bus.wb_ack_o !== 1'b0)   begin n_fails++; $display("FAIL reset_ack: got %0b want 0", bus.wb_ack_o); end
      if (bus.wb_dat_o !== 32'h0)  begin n_fails++; $display("FAIL reset_dat: got %08h want 0", bus.wb_dat_o); end
      if (out_valid !== 1'b0)      begin n_fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
      if (out_data !== 8'h00)      begin n_fails++; $display("FAIL reset_data: got %02h want 00", out_data); end
      if (block_done !== 1'b0)     begin n_fails++; $display("FAIL reset_done: got %0b want 0", block_done); end
      if (fifo_level !== '0)       begin n_fails++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      if (overflow_err !== 1'b0)   begin n_fails++; $display("FAIL reset_ovf: got %0b want 0", overflow_err); end
      reset_n = 1'b1;
      model_clear();
   endtask

   task automatic test_stream();
      logic [31:0] words [4];
      words[0] = 32'h03020100;
      words[1] = 32'h07060504;
      words[2] = 32'h0B0A0908;
      words[3] = 32'h0F0E0D0C;
      out_ready = 1'b1;
      acc_cyc.delete();
      for (int i = 0; i < 4; i++) wb_write(words[i], 4'hF);
      wait_drain("stream");
      n_checks++;
      if (acc_cyc.size() != 16) begin
         n_fails++;
         $display("FAIL stream_count: got %0d bytes want 16", acc_cyc.size());
      end else begin
         for (int i = 1; i < 16; i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 1) begin
               n_fails++;
               $display("FAIL stream_gap: got %0d cycles before byte %0d want 1", acc_cyc[i] - acc_cyc[i-1], i);
            end
         end
      end
   endtask

   task automatic test_stall();
      bit          acked;
      logic [31:0] rd;
      logic [31:0] w;
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) wb_write($urandom, 4'hF);
      @(negedge clk);
      n_checks += 2;
      if (fifo_level !== (FIFO_DEPTH_LOG2+1)'(DEPTH)) begin
         n_fails++;
         $display("FAIL stall_level: got %0d want %0d", fifo_level, DEPTH);
      end
      if (out_valid !== 1'b1) begin
         n_fails++;
         $display("FAIL stall_valid: got %0b want 1", out_valid);
      end
      w = $urandom;
      wb_drive(w, 4'hF, 1'b1);
      wb_wait(20, acked, rd);
      n_checks++;
      if (acked) begin
         n_fails++;
         $display("FAIL stall_wait: got ack want no ack while full");
         model_push(w);
      end else begin
         out_ready = 1'b1;
         wb_wait(200, acked, rd);
         n_checks++;
         if (!acked) begin
            n_fails++;
            $display("FAIL stall_release: got no ack want ack after ready");
            bus.wb_cyc_i = 1'b0;
            bus.wb_stb_i = 1'b0;
         end else begin
            model_push(w);
         end
      end
      out_ready = 1'b1;
      wait_drain("stall");
   endtask

   task automatic test_random();
      bit wr_done = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) wb_write($urandom, 4'hF);
            wr_done = 1;
         end
         begin
            while (!wr_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_drain("random");
   endtask

   task automatic test_block();
      do_flush();
      out_ready   = 1'b1;
      done_pulses = 0;
      for (int i = 0; i < 128; i++) wb_write($urandom, 4'hF);
      wait_drain("block1");
      repeat (2) @(negedge clk);
      n_checks++;
      if (done_pulses != 1) begin
         n_fails++;
         $display("FAIL block_one: got %0d pulses want 1", done_pulses);
      end
      for (int i = 0; i < 128; i++) wb_write($urandom, 4'hF);
      wait_drain("block2");
      repeat (2) @(negedge clk);
      n_checks++;
      if (done_pulses != 2) begin
         n_fails++;
         $display("FAIL block_two: got %0d pulses want 2", done_pulses);
      end
   endtask

   task automatic test_overflow();
      out_ready = 1'b1;
      wb_write($urandom, 4'b0011);
      repeat (8) @(negedge clk);
      n_checks += 3;
      if (out_valid !== 1'b0)    begin n_fails++; $display("FAIL ovf_nobyte: got valid %0b want 0", out_valid); end
      if (fifo_level !== '0)     begin n_fails++; $display("FAIL ovf_level: got %0d want 0", fifo_level); end
      if (overflow_err !== 1'b1) begin n_fails++; $display("FAIL ovf_set: got %0b want 1", overflow_err); end
      do_flush();
      @(negedge clk);
      n_checks++;
      if (overflow_err !== 1'b1) begin n_fails++; $display("FAIL ovf_sticky: got %0b want 1", overflow_err); end
   endtask

   task automatic test_read();
      bit          acked;
      logic [31:0] rd;
      out_ready = 1'b0;
      wb_write($urandom, 4'hF);
      wb_write($urandom, 4'hF);
      @(negedge clk);
      n_checks++;
      if (fifo_level !== 7'd1) begin n_fails++; $display("FAIL read_pre_level: got %0d want 1", fifo_level); end
      wb_drive($urandom, 4'hF, 1'b0);
      wb_wait(50, acked, rd);
      n_checks += 3;
      if (!acked) begin
         n_fails++;
         $display("FAIL read_ack: got no ack want ack");
         bus.wb_cyc_i = 1'b0;
         bus.wb_stb_i = 1'b0;
      end
      if (rd !== 32'h0)        begin n_fails++; $display("FAIL read_data: got %08h want 0", rd); end
      if (fifo_level !== 7'd1) begin n_fails++; $display("FAIL read_level: got %0d want 1", fifo_level); end
      out_ready = 1'b1;
      wait_drain("read");
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) wb_write($urandom, 4'hF);
      @(negedge clk);
      n_checks++;
      if (fifo_level !== 7'd5) begin n_fails++; $display("FAIL flush_pre_level: got %0d want 5", fifo_level); end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
      do_flush();
      @(negedge clk);
      n_checks += 2;
      if (out_valid !== 1'b0) begin n_fails++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
      if (fifo_level !== '0)  begin n_fails++; $display("FAIL flush_level: got %0d want 0", fifo_level); end
      out_ready = 1'b1;
      wb_write(32'hA3A2A1A0 ^ $urandom, 4'hF);
      wait_drain("flush");
   endtask

   task automatic test_reset_mid_ack();
      bit seen = 0;
      out_ready = 1'b1;
      wb_drive($urandom, 4'hF, 1'b1);
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (bus.wb_ack_o === 1'b1) seen = 1;
      end
      n_checks++;
      if (!seen) begin n_fails++; $display("FAIL rst_ack_seen: got no ack want ack"); end
      #1 reset_n = 1'b0;
      #1;
      n_checks += 3;
      if (bus.wb_ack_o !== 1'b0) begin n_fails++; $display("FAIL rst_ack_drop: got %0b want 0", bus.wb_ack_o); end
      if (fifo_level !== '0)     begin n_fails++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
      if (out_valid !== 1'b0)    begin n_fails++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      model_clear();
      @(negedge clk);
      reset_n = 1'b1;
      wb_write($urandom, 4'hF);
      wait_drain("after_reset");
   endtask

   // ---------------------------------------------------------------------
   // Sequence
   // ---------------------------------------------------------------------
   initial begin
      reset_n      = 1'b0;
      flush        = 1'b0;
      out_ready    = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_sel_i = '0;
      bus.wb_we_i  = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_cti_i = '0;
      bus.wb_bte_i = '0;

      test_reset();
      test_stream();
      test_stall();
      test_random();
      test_block();
      test_overflow();
      test_read();
      test_flush();
      test_reset_mid_ack();

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion want completion within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sd_dma_sink.md
# sd_dma_sink

Wishbone slave that terminates the SD controller's DMA master port (`m_wb_*`) and turns the 32-bit block-data writes into a byte stream for the frame decoder. It sits directly downstream of the SD card controller and its bus master. Internally it has a word FIFO, a word-to-byte unpacker and a 512-byte block tracker.

## Interface
- `FIFO_DEPTH_LOG2`, 6: FIFO depth is 2^N 32-bit words. Legal range is 2..10.
- `BLOCK_BYTES_LOG2`, 9: block length is 2^N bytes. Default 9 gives 512.

Ports:
- `clk` in 1: single clock. It is also the Wishbone clock.
- `reset_n` in 1: asynchronous reset, active-low.
- `wb_adr_i` in 32: DMA address. Ignored.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte selects.
- `wb_we_i` in 1: write enable.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_cti_i` in 3: cycle type. Ignored; every beat is treated as classic.
- `wb_bte_i` in 2: burst type. Ignored.
- `wb_ack_o` out 1: registered single-cycle acknowledge.
- `wb_dat_o` out 32: read data. Always 0.
- `flush` in 1: synchronous clear of FIFO, unpacker and block counter.
- `out_data` out 8: stream byte.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready.
- `block_done` out 1: one-cycle pulse when the last byte of a block is accepted.
- `fifo_level` out FIFO_DEPTH_LOG2+1: words currently stored in the FIFO.
- `overflow_err` out 1: sticky flag, set by any write with `wb_sel_i` not equal to 1111.

## Operation
**Bus FSM** (states IDLE, ACK):
- IDLE → ACK when `wb_cyc_i & wb_stb_i` and `fifo_level < 2^FIFO_DEPTH_LOG2`, sampled on the edge.
- On that same edge, a write with `wb_sel_i`==1111 pushes `wb_dat_i` into the FIFO.
- A write with any other `wb_sel_i` is acked and dropped, and sets `overflow_err`.
- A read is acked with `wb_dat_o`=0 and does not push.
- ACK → IDLE unconditionally. `wb_ack_o`=1 only while in ACK.
- Consequence: at most one beat every 2 cycles, and a request is never acked twice.
- FIFO full: the request is held in IDLE with no ack (wait states). The full test uses the registered level only; a pop on the same edge does not allow the push.

**FIFO**:
- Circular buffer with read and write pointers of FIFO_DEPTH_LOG2 bits each; both wrap modulo depth.
- `fifo_level` = pushes − pops. A simultaneous push and pop leaves it unchanged.

**Unpacker**:
- Holds one word plus a 2-bit byte index. `out_valid` is high while a word is held.
- Load: when empty, or when byte 3 is accepted and the FIFO is non-empty, the head word is popped and loaded with index 0 on the same edge. There is no bubble between words.
- Byte order: byte k = `word[8k+7:8k]`, so `[7:0]` is sent first (see Configuration).
- Accept: `out_valid & out_ready` increments the index. Index 3 accepted with the FIFO empty makes `out_valid` go 0 next cycle.
- `out_data` is stable while `out_valid & !out_ready`.

**Block tracker**:
- BLOCK_BYTES_LOG2-bit byte counter, incremented on every accepted byte.
- `block_done` = 1 for the cycle after the accept that wraps the counter to 0.

**flush**:
- Highest priority. Empties the FIFO and unpacker and zeroes the counter.
- Forces the bus FSM to IDLE with no ack in that cycle. A still-asserted strobe is served normally afterwards.
- Does not clear `overflow_err`; only reset clears it.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `out_valid`=0, `out_data`=0, `block_done`=0, `fifo_level`=0, `overflow_err`=0. FSM in IDLE.
- Strobe sampled at edge N: ack high N→N+1. Pushed word shows in `fifo_level` after N.
- `out_valid` rises after edge N+1 at the earliest (2-cycle write-to-stream latency from an empty block).
- Sustained output: 1 byte per cycle while `out_ready`=1 and the FIFO holds data. Input peak is 2 bytes per cycle, so the FIFO absorbs the rate difference.
- Reset asserted mid-cycle: all state clears immediately. Any in-flight ack is dropped, and the bus master times out or retries.

## Configuration
- `SD_DMA_SINK_BYTE_SWAP_EN` defined: byte k = `word[31-8k:24-8k]`, so `[31:24]` is sent first. This matches SD wire order when the controller packs big-endian.
- Not defined: `[7:0]` first, as described in Operation.
- Nothing else changes.

## Test plan
- Reset, then 4 writes of 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with `out_ready`=1 → bytes 0x00..0x0F in order with no gaps after the first. Each ack is exactly 1 cycle. With the swap macro defined: 0x03,0x02,0x01,0x00,...
- `out_ready`=0 and 2^FIFO_DEPTH_LOG2+2 writes issued → the first 2^N+1 are acked (FIFO plus unpacker) and the next is stalled with `wb_ack_o`=0. Raising `out_ready` releases the stall, with no loss or duplication.
- 128 words written (512 bytes) → exactly one `block_done` pulse, in the cycle after byte 511 is accepted. 256 words → two pulses.
- Write with `wb_sel_i`=0011 → acked, no byte emitted, `overflow_err`=1, and it persists across `flush`.
- Read cycle → ack with `wb_dat_o`=0 and `fifo_level` unchanged.
- `flush` asserted with 5 words buffered and the stream mid-word → next cycle `out_valid`=0 and `fifo_level`=0. A new write afterwards emits its byte 0 first.
- `reset_n` dropped during ACK → `wb_ack_o`=0 immediately.
